// File: rtl/prog_seq.sv
`default_nettype none
// ============================================================================
// Module   : prog_seq
// Brief    : Programmable instruction sequencer that steps a PC through a
//            latency-LAT instruction ROM, with branch, halt and stall support.
// Revision : 1.0 - initial release
// ============================================================================
module prog_seq #(
    parameter int PC_W     = 10,
    parameter int LAT      = 1,
    parameter int CNT_W    = 16,
    parameter int REL_BR   = 0,
    parameter int START_PC = 0
) (
    input  logic             Clk,
    input  logic             Reset,
    input  logic             Start,
    input  logic             Halt,
    input  logic             BranchEn,
    input  logic [PC_W-1:0]  Target,
    input  logic             Stall,
    output logic [PC_W-1:0]  InstAddr,
    output logic             IssueValid,
    output logic             Busy,
    output logic             Ack,
    output logic             WrapErr,
    output logic [CNT_W-1:0] CycleCt,
    output logic [CNT_W-1:0] InstCt
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        FETCH = 2'd1,
        EXEC  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic [PC_W-1:0]  START_V  = PC_W'(START_PC);
    localparam logic [1:0]       LAT_LAST = 2'(LAT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;
    localparam logic [PC_W-1:0]  PC_MAX   = '1;

    state_t           state, state_nx;
    logic [PC_W-1:0]  pc, pc_nx;
    logic [1:0]       lat_cnt, lat_nx;
    logic [CNT_W-1:0] cycle_ct, cycle_nx;
    logic [CNT_W-1:0] inst_ct, inst_nx;
    logic             wrap_err, wrap_nx;
    logic             start_q;
    logic             start_ev;

    // Two guard bits: the top one flags a borrow below 0, the next one a carry past PC_MAX.
    logic signed [PC_W+1:0] rel_sum;
    logic                   rel_wrap;

    assign start_ev = Start & ~start_q;
    assign rel_sum  = $signed({2'b00, pc}) + $signed({{2{Target[PC_W-1]}}, Target});
    assign rel_wrap = rel_sum[PC_W+1] | rel_sum[PC_W];

    always_ff @(posedge Clk or negedge Reset) begin
        if (!Reset) begin
            state    <= IDLE;
            pc       <= START_V;
            lat_cnt  <= '0;
            cycle_ct <= '0;
            inst_ct  <= '0;
            wrap_err <= 1'b0;
            start_q  <= 1'b0;
        end else begin
            state    <= state_nx;
            pc       <= pc_nx;
            lat_cnt  <= lat_nx;
            cycle_ct <= cycle_nx;
            inst_ct  <= inst_nx;
            wrap_err <= wrap_nx;
            start_q  <= Start;
        end
    end

    always_comb begin
        state_nx = state;
        pc_nx    = pc;
        lat_nx   = lat_cnt;
        cycle_nx = cycle_ct;
        inst_nx  = inst_ct;
        wrap_nx  = wrap_err;

        if ((state == FETCH || state == EXEC) && cycle_ct != CNT_MAX) begin
            cycle_nx = cycle_ct + 1'b1;
        end

        case (state)
            IDLE, DONE: begin
                if (start_ev) begin
                    state_nx = FETCH;
                    pc_nx    = START_V;
                    lat_nx   = '0;
                    cycle_nx = '0;
                    inst_nx  = '0;
                    wrap_nx  = 1'b0;
                end
            end
            FETCH: begin
                if (lat_cnt == LAT_LAST) begin
                    state_nx = EXEC;
                end else begin
                    lat_nx = lat_cnt + 1'b1;
                end
            end
            EXEC: begin
                if (!Stall) begin
                    if (inst_ct != CNT_MAX) begin
                        inst_nx = inst_ct + 1'b1;
                    end
                    if (Halt) begin
                        state_nx = DONE;
                    end else begin
                        state_nx = FETCH;
                        lat_nx   = '0;
                        if (BranchEn) begin
                            if (REL_BR != 0) begin
                                pc_nx = rel_sum[PC_W-1:0];
                                if (rel_wrap) wrap_nx = 1'b1;
                            end else begin
                                pc_nx = Target;
                            end
                        end else begin
                            pc_nx = pc + 1'b1;
                            if (pc == PC_MAX) wrap_nx = 1'b1;
                        end
                    end
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign InstAddr   = pc;
    assign IssueValid = (state == EXEC);
    assign Busy       = (state == FETCH) || (state == EXEC);
    assign Ack        = (state == DONE);
    assign WrapErr    = wrap_err;
    assign CycleCt    = cycle_ct;
    assign InstCt     = inst_ct;

endmodule
`default_nettype wire

// File: tb/tb_prog_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_prog_seq
// Brief    : Scoreboard bench for prog_seq over three parameter sets
//            (LAT=1 absolute, LAT=3 absolute, LAT=1 relative branches).
// Revision : 1.0 - initial release
// ============================================================================
module tb_prog_seq;

    localparam int N = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        start [N];
    logic        halt  [N];
    logic        br    [N];
    logic        stall [N];
    logic [9:0]  tgt   [N];
    logic [9:0]  addr  [N];
    logic        iv    [N];
    logic        busy  [N];
    logic        ack   [N];
    logic        wrap  [N];
    logic [15:0] cyc   [N];
    logic [15:0] ict   [N];

    generate
        for (genvar g = 0; g < N; g++) begin : g_dut
            prog_seq #(
                .PC_W    (10),
                .LAT     ((g == 1) ? 3 : 1),
                .CNT_W   (16),
                .REL_BR  ((g == 2) ? 1 : 0),
                .START_PC(0)
            ) u_dut (
                .Clk       (clk),
                .Reset     (rst_n),
                .Start     (start[g]),
                .Halt      (halt[g]),
                .BranchEn  (br[g]),
                .Target    (tgt[g]),
                .Stall     (stall[g]),
                .InstAddr  (addr[g]),
                .IssueValid(iv[g]),
                .Busy      (busy[g]),
                .Ack       (ack[g]),
                .WrapErr   (wrap[g]),
                .CycleCt   (cyc[g]),
                .InstCt    (ict[g])
            );
        end
    endgenerate

    typedef struct {
        bit          is_ack;
        logic [9:0]  a;
        logic [15:0] c;
        logic [15:0] i;
        logic        w;
    } ev_t;

    ev_t sbq [N][$];
    int  checks = 0;
    int  errors = 0;
    logic ack_q [N];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic exp_issue(input int k, input logic [9:0] a, input logic [15:0] i);
        ev_t e;
        e.is_ack = 1'b0; e.a = a; e.c = '0; e.i = i; e.w = 1'b0;
        sbq[k].push_back(e);
    endtask

    task automatic exp_ack(input int k, input logic [9:0] a, input logic [15:0] c,
                           input logic [15:0] i, input logic w);
        ev_t e;
        e.is_ack = 1'b1; e.a = a; e.c = c; e.i = i; e.w = w;
        sbq[k].push_back(e);
    endtask

    // Monitor: every EXEC cycle and every Ack rising edge consumes one expectation.
    initial for (int k = 0; k < N; k++) ack_q[k] = 1'b0;
    always @(negedge clk) begin
        #1;
        for (int k = 0; k < N; k++) begin
            ev_t e;
            if (iv[k] || (ack[k] && !ack_q[k])) begin
                if (sbq[k].size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL dut%0d_unexpected: iv=%0b ack=%0b addr=0x%0h, expected no event",
                             k, iv[k], ack[k], addr[k]);
                end else begin
                    e = sbq[k].pop_front();
                    check($sformatf("dut%0d_kind", k), {31'd0, ack[k] && !iv[k]}, {31'd0, e.is_ack});
                    check($sformatf("dut%0d_addr", k), {22'd0, addr[k]}, {22'd0, e.a});
                    check($sformatf("dut%0d_instct", k), {16'd0, ict[k]}, {16'd0, e.i});
                    if (e.is_ack) begin
                        check($sformatf("dut%0d_cyclect", k), {16'd0, cyc[k]}, {16'd0, e.c});
                        check($sformatf("dut%0d_wraperr", k), {31'd0, wrap[k]}, {31'd0, e.w});
                        check($sformatf("dut%0d_busy_done", k), {31'd0, busy[k]}, 32'd0);
                    end
                end
            end
            ack_q[k] = ack[k];
        end
    end

    task automatic wait_issue(input int k, output int waited);
        waited = 0;
        while (!iv[k] && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        if (!iv[k]) begin
            checks++;
            errors++;
            $display("FAIL dut%0d_issue_timeout: IssueValid=0 after %0d cycles, expected 1", k, waited);
        end
    endtask

    // Drive one instruction's decode inputs while it sits in EXEC (nstall extra cycles).
    task automatic issue(input int k, input logic h, input logic b, input logic [9:0] tg,
                         input int nstall, input logic [9:0] ea, input logic [15:0] ei,
                         input int expwait);
        int w;
        wait_issue(k, w);
        if (expwait >= 0) check($sformatf("dut%0d_issue_latency", k), w, expwait);
        halt[k] = h; br[k] = b; tgt[k] = tg;
        for (int s = 0; s < nstall; s++) begin
            stall[k] = 1'b1;
            exp_issue(k, ea, ei);
            @(negedge clk);
        end
        stall[k] = 1'b0;
        exp_issue(k, ea, ei);
        @(negedge clk);
        halt[k] = 1'b0; br[k] = 1'b0; tgt[k] = '0;
    endtask

    task automatic check_reset_state(input int k, input string tag);
        check($sformatf("%s_iv", tag),    {31'd0, iv[k]},   32'd0);
        check($sformatf("%s_busy", tag),  {31'd0, busy[k]}, 32'd0);
        check($sformatf("%s_ack", tag),   {31'd0, ack[k]},  32'd0);
        check($sformatf("%s_wrap", tag),  {31'd0, wrap[k]}, 32'd0);
        check($sformatf("%s_addr", tag),  {22'd0, addr[k]}, 32'd0);
        check($sformatf("%s_cyc", tag),   {16'd0, cyc[k]},  32'd0);
        check($sformatf("%s_ict", tag),   {16'd0, ict[k]},  32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation still running, expected completion");
        $fatal(1, "timeout");
    end

    initial begin
        for (int k = 0; k < N; k++) begin
            start[k] = 1'b0; halt[k] = 1'b0; br[k] = 1'b0; stall[k] = 1'b0; tgt[k] = '0;
        end
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        for (int k = 0; k < N; k++) check_reset_state(k, $sformatf("dut%0d_reset", k));
        rst_n = 1'b1;
        @(negedge clk);

        // Three sequential instructions, halt on the fourth.
        start[0] = 1'b1;
        issue(0, 0, 0, 0, 0, 10'd0, 16'd0, -1);
        issue(0, 0, 0, 0, 0, 10'd1, 16'd1, 1);
        issue(0, 0, 0, 0, 0, 10'd2, 16'd2, 1);
        issue(0, 1, 0, 0, 0, 10'd3, 16'd3, 1);
        exp_ack(0, 10'd3, 16'd8, 16'd4, 1'b0);
        repeat (3) @(negedge clk);
        check("done_ack_held", {31'd0, ack[0]}, 32'd1);
        check("done_cyc_frozen", {16'd0, cyc[0]}, 32'd8);

        // Restart, ignored mid-program start pulse, 4-cycle stall on the halt.
        start[0] = 1'b0; @(negedge clk);
        start[0] = 1'b1; @(negedge clk);
        check("restart_busy", {31'd0, busy[0]}, 32'd1);
        check("restart_cyc_cleared", {16'd0, cyc[0]}, 32'd0);
        check("restart_ict_cleared", {16'd0, ict[0]}, 32'd0);
        start[0] = 1'b0; @(negedge clk);
        start[0] = 1'b1;
        issue(0, 0, 0, 0, 0, 10'd0, 16'd0, 0);
        issue(0, 1, 0, 0, 4, 10'd1, 16'd1, 1);
        exp_ack(0, 10'd1, 16'd8, 16'd2, 1'b0);
        repeat (4) @(negedge clk);
        check("start_held_no_restart_ack", {31'd0, ack[0]}, 32'd1);
        check("start_held_no_restart_busy", {31'd0, busy[0]}, 32'd0);

        // Fresh edge restarts with counters cleared.
        start[0] = 1'b0; @(negedge clk);
        start[0] = 1'b1;
        issue(0, 1, 0, 0, 0, 10'd0, 16'd0, -1);
        exp_ack(0, 10'd0, 16'd2, 16'd1, 1'b0);

        // Asynchronous reset during FETCH of the second instruction.
        start[0] = 1'b0; @(negedge clk);
        start[0] = 1'b1;
        issue(0, 0, 0, 0, 0, 10'd0, 16'd0, -1);
        check("prereset_busy", {31'd0, busy[0]}, 32'd1);
        check("prereset_addr", {22'd0, addr[0]}, 32'd1);
        #2 rst_n = 1'b0;
        #1 check_reset_state(0, "async_reset");
        start[0] = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        check("post_reset_idle_busy", {31'd0, busy[0]}, 32'd0);
        check("post_reset_idle_ack", {31'd0, ack[0]}, 32'd0);

        // Start held through reset release counts as a start event.
        rst_n = 1'b0; start[0] = 1'b1;
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("start_through_reset_busy", {31'd0, busy[0]}, 32'd1);
        issue(0, 1, 0, 0, 0, 10'd0, 16'd0, 1);
        exp_ack(0, 10'd0, 16'd2, 16'd1, 1'b0);

        // LAT=3, absolute branch to 0x155.
        start[1] = 1'b1;
        issue(1, 0, 0, 0, 0, 10'd0, 16'd0, -1);
        issue(1, 0, 0, 0, 0, 10'd1, 16'd1, 3);
        issue(1, 0, 1, 10'h155, 0, 10'd2, 16'd2, 3);
        check("abs_branch_addr", {22'd0, addr[1]}, 32'h155);
        check("abs_branch_fetch_iv", {31'd0, iv[1]}, 32'd0);
        issue(1, 1, 0, 0, 0, 10'h155, 16'd3, 3);
        exp_ack(1, 10'h155, 16'd16, 16'd4, 1'b0);

        // Relative branches: 0 -> 5 -> 3 -> 0x202 -> 0x3FF, then sequential wrap to 0.
        start[2] = 1'b1;
        issue(2, 0, 1, 10'd5,   0, 10'd0, 16'd0, -1);
        issue(2, 0, 1, 10'h3FE, 0, 10'd5, 16'd1, 1);
        check("rel_back_addr", {22'd0, addr[2]}, 32'd3);
        check("rel_back_wrap", {31'd0, wrap[2]}, 32'd0);
        issue(2, 0, 1, 10'h1FF, 0, 10'd3, 16'd2, 1);
        check("rel_fwd_addr", {22'd0, addr[2]}, 32'h202);
        issue(2, 0, 1, 10'h1FD, 0, 10'h202, 16'd3, 1);
        check("rel_top_addr", {22'd0, addr[2]}, 32'h3FF);
        check("rel_top_wrap", {31'd0, wrap[2]}, 32'd0);
        issue(2, 0, 0, 0, 0, 10'h3FF, 16'd4, 1);
        check("seq_wrap_addr", {22'd0, addr[2]}, 32'd0);
        check("seq_wrap_flag", {31'd0, wrap[2]}, 32'd1);
        issue(2, 1, 0, 0, 0, 10'd0, 16'd5, 1);
        exp_ack(2, 10'd0, 16'd12, 16'd6, 1'b1);

        // Restart clears the sticky flag; then a relative borrow sets it.
        start[2] = 1'b0; @(negedge clk);
        start[2] = 1'b1;
        issue(2, 1, 0, 0, 0, 10'd0, 16'd0, -1);
        exp_ack(2, 10'd0, 16'd2, 16'd1, 1'b0);
        start[2] = 1'b0; @(negedge clk);
        start[2] = 1'b1;
        issue(2, 0, 1, 10'h3FC, 0, 10'd0, 16'd0, -1);
        check("rel_borrow_addr", {22'd0, addr[2]}, 32'h3FC);
        check("rel_borrow_wrap", {31'd0, wrap[2]}, 32'd1);
        issue(2, 1, 0, 0, 0, 10'h3FC, 16'd1, 1);
        exp_ack(2, 10'h3FC, 16'd4, 16'd2, 1'b1);

        repeat (3) @(negedge clk);
        #2;
        for (int k = 0; k < N; k++) begin
            checks++;
            if (sbq[k].size() != 0) begin
                errors++;
                $display("FAIL dut%0d_pending: %0d expected events never seen, expected 0",
                         k, sbq[k].size());
            end
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
